// File: rtl/tone_player.sv
// Square-wave tone generator: plays one of eight notes (C4..C5) with an octave
// shift for a programmed number of prescaled ticks, with start/stop/busy/done handshake.
module tone_player #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int CNT_W    = 19,
  parameter int TICK_DIV = 100_000,
  parameter int DUR_W    = 8
) (
  input  logic             clk,
  input  logic             hush,
  input  logic             start,
  input  logic             stop,
  input  logic [2:0]       note,
  input  logic [1:0]       octave,
  input  logic [DUR_W-1:0] dur,
  output logic             busy,
  output logic             done,
  output logic             ampPWM
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {IDLE, PLAY} state_t;

  function automatic logic [CNT_W-1:0] half_period(input int k);
    int f;
    case (k)
      0:       f = 262;
      1:       f = 294;
      2:       f = 330;
      3:       f = 349;
      4:       f = 392;
      5:       f = 440;
      6:       f = 494;
      default: f = 523;
    endcase
    return CNT_W'(CLK_HZ / (2 * f));
  endfunction

  localparam logic [CNT_W-1:0] HP_TABLE [8] = '{
    half_period(0), half_period(1), half_period(2), half_period(3),
    half_period(4), half_period(5), half_period(6), half_period(7)
  };

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   hpe_q, hpe_d;
  logic [CNT_W-1:0]   hp_cnt_q, hp_cnt_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic               amp_q, amp_d;
  logic               done_q, done_d;

  logic [CNT_W-1:0]   hp_shift;
  logic [CNT_W-1:0]   hpe_new;
  logic               tick_wrap;
  logic               expire;

  // Very high notes at large shifts could truncate to zero; a half-period of 1 is the floor.
  assign hp_shift = HP_TABLE[note] >> octave;
  assign hpe_new  = (hp_shift == '0) ? CNT_W'(1) : hp_shift;

  assign tick_wrap = (tick_q == TICK_W'(TICK_DIV - 1));
  assign expire    = tick_wrap && (dur_q == DUR_W'(1));

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    hpe_d    = hpe_q;
    hp_cnt_d = hp_cnt_q;
    tick_d   = tick_q;
    dur_d    = dur_q;
    amp_d    = amp_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        amp_d = 1'b0;
        if (start && !stop) begin
          state_d  = PLAY;
          hpe_d    = hpe_new;
          dur_d    = dur;
          tick_d   = '0;
          hp_cnt_d = '0;
          amp_d    = 1'b1;
        end
      end
      PLAY: begin
        if (stop || expire) begin
          // Stop and expiry on the same edge collapse into one done pulse.
          state_d  = IDLE;
          done_d   = 1'b1;
          amp_d    = 1'b0;
          tick_d   = '0;
          hp_cnt_d = '0;
          dur_d    = '0;
        end else begin
          if (hp_cnt_q == hpe_q - CNT_W'(1)) begin
            amp_d    = ~amp_q;
            hp_cnt_d = '0;
          end else begin
            hp_cnt_d = hp_cnt_q + CNT_W'(1);
          end
          tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
          // A zero duration never decrements, so the note runs until stop.
          if (tick_wrap && dur_q != '0) dur_d = dur_q - DUR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge hush) begin
    if (!hush) begin
      state_q  <= IDLE;
      hpe_q    <= '0;
      hp_cnt_q <= '0;
      tick_q   <= '0;
      dur_q    <= '0;
      amp_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hpe_q    <= hpe_d;
      hp_cnt_q <= hp_cnt_d;
      tick_q   <= tick_d;
      dur_q    <= dur_d;
      amp_q    <= amp_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == PLAY);
  assign done   = done_q;
  assign ampPWM = amp_q;

endmodule

// File: tb/tb_tone_player.sv
// Directed bench for tone_player at CLK_HZ=8800, TICK_DIV=4: checks {busy,done,ampPWM}
// cycle by cycle against hand-computed half-periods and durations.
module tb_tone_player;

  logic       clk = 1'b0;
  logic       hush = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [2:0] note = '0;
  logic [1:0] octave = '0;
  logic [7:0] dur = '0;
  logic       busy, done, ampPWM;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  tone_player #(
    .CLK_HZ(8800), .CNT_W(19), .TICK_DIV(4), .DUR_W(8)
  ) dut (
    .clk(clk), .hush(hush), .start(start), .stop(stop),
    .note(note), .octave(octave), .dur(dur),
    .busy(busy), .done(done), .ampPWM(ampPWM)
  );

  // Cycle k of a note is the k-th clock period after the edge that samples start.
  function automatic logic [2:0] playing(input int k, input int hpe);
    return {1'b1, 1'b0, (((k - 1) / hpe) % 2) == 0};
  endfunction

  // Drives start for one edge; returns just after that edge (start of cycle 1).
  task automatic begin_note(input logic [2:0] n, input logic [1:0] o, input logic [7:0] d);
    @(negedge clk);
    note = n; octave = o; dur = d; start = 1'b1; stop = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    compared++;
    if ({busy, done, ampPWM} !== 3'b000) begin
      $display("FAIL reset: {busy,done,amp}=%b expected 000", {busy, done, ampPWM});
      mismatched++;
    end
    @(negedge clk) hush = 1'b1;
  endtask

  // note 5, oct 0: HPe=10, busy 12 cycles, done at 13.
  task automatic test_basic_expiry();
    logic [2:0] exp;
    begin_note(3'd5, 2'd0, 8'd3);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      exp = (k <= 12) ? playing(k, 10) : (k == 13) ? 3'b010 : 3'b000;
      compared++;
      if ({busy, done, ampPWM} !== exp) begin
        $display("FAIL basic cycle %0d: {busy,done,amp}=%b expected %b", k, {busy, done, ampPWM}, exp);
        mismatched++;
      end
    end
  endtask

  // note 0, oct 2: HPe=16>>2=4, two full periods over 16 cycles.
  task automatic test_octave_shift();
    logic [2:0] exp;
    begin_note(3'd0, 2'd2, 8'd4);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      exp = (k <= 16) ? playing(k, 4) : (k == 17) ? 3'b010 : 3'b000;
      compared++;
      if ({busy, done, ampPWM} !== exp) begin
        $display("FAIL octave cycle %0d: {busy,done,amp}=%b expected %b", k, {busy, done, ampPWM}, exp);
        mismatched++;
      end
    end
  endtask

  // note 7, oct 3: HPe=8>>3=1, toggles every cycle; a start during busy is ignored.
  task automatic test_fast_and_restart_ignored();
    logic [2:0] exp;
    begin_note(3'd7, 2'd3, 8'd1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp = (k <= 4) ? playing(k, 1) : (k == 5) ? 3'b010 : 3'b000;
      compared++;
      if ({busy, done, ampPWM} !== exp) begin
        $display("FAIL fast cycle %0d: {busy,done,amp}=%b expected %b", k, {busy, done, ampPWM}, exp);
        mismatched++;
      end
      start = (k == 2);
    end
  endtask

  // dur=0 runs until stop; stop sampled after cycle `stop_at` gives done in the next cycle.
  task automatic test_continuous(input int stop_at);
    logic [2:0] exp;
    begin_note(3'd4, 2'd0, 8'd0);
    for (int k = 1; k <= stop_at + 3; k++) begin
      @(negedge clk);
      exp = (k <= stop_at) ? playing(k, 11) : (k == stop_at + 1) ? 3'b010 : 3'b000;
      compared++;
      if ({busy, done, ampPWM} !== exp) begin
        $display("FAIL continuous(%0d) cycle %0d: {busy,done,amp}=%b expected %b",
                 stop_at, k, {busy, done, ampPWM}, exp);
        mismatched++;
      end
      stop = (k == stop_at);
    end
  endtask

  task automatic test_start_with_stop();
    @(negedge clk);
    start = 1'b1; stop = 1'b1; note = 3'd5; dur = 8'd3;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      compared++;
      if ({busy, done, ampPWM} !== 3'b000) begin
        $display("FAIL start_with_stop cycle %0d: {busy,done,amp}=%b expected 000", k, {busy, done, ampPWM});
        mismatched++;
      end
      @(negedge clk);
    end
  endtask

  // A start presented while done is high must launch the next note immediately.
  task automatic test_back_to_back();
    logic [2:0] exp;
    begin_note(3'd5, 2'd0, 8'd1);
    for (int k = 1; k <= 4; k++) @(negedge clk);
    @(negedge clk);
    compared++;
    if ({busy, done, ampPWM} !== 3'b010) begin
      $display("FAIL b2b first done: {busy,done,amp}=%b expected 010", {busy, done, ampPWM});
      mismatched++;
    end
    note = 3'd7; octave = 2'd0; dur = 8'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp = (k <= 4) ? playing(k, 8) : (k == 5) ? 3'b010 : 3'b000;
      compared++;
      if ({busy, done, ampPWM} !== exp) begin
        $display("FAIL b2b second cycle %0d: {busy,done,amp}=%b expected %b", k, {busy, done, ampPWM}, exp);
        mismatched++;
      end
    end
  endtask

  task automatic test_hush_mid_note();
    logic [2:0] exp;
    begin_note(3'd5, 2'd0, 8'd3);
    for (int k = 1; k <= 6; k++) @(negedge clk);
    hush = 1'b0;
    #1;
    compared++;
    if ({busy, done, ampPWM} !== 3'b000) begin
      $display("FAIL hush immediate: {busy,done,amp}=%b expected 000", {busy, done, ampPWM});
      mismatched++;
    end
    repeat (3) @(negedge clk);
    hush = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      compared++;
      if ({busy, done, ampPWM} !== 3'b000) begin
        $display("FAIL hush release cycle %0d: {busy,done,amp}=%b expected 000", k, {busy, done, ampPWM});
        mismatched++;
      end
    end
    begin_note(3'd5, 2'd0, 8'd3);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      exp = (k <= 12) ? playing(k, 10) : (k == 13) ? 3'b010 : 3'b000;
      compared++;
      if ({busy, done, ampPWM} !== exp) begin
        $display("FAIL post-hush cycle %0d: {busy,done,amp}=%b expected %b", k, {busy, done, ampPWM}, exp);
        mismatched++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_expiry();
    test_octave_shift();
    test_fast_and_restart_ignored();
    test_continuous(50);
    test_continuous(120);
    test_start_with_stop();
    test_back_to_back();
    test_hush_mid_note();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tone_player.md
Name: tone_player

Overview:
- Parametrised tone generator for the speaker amplifier.
- Plays one of 8 notes (C4..C5), with octave shift 0..3 up, for a programmed duration measured in prescaled ticks.
- Uses a start/stop/busy/done handshake so a higher-level sequencer (game/VGA event logic) can queue beeps and melodies.
- Output is a registered 50%-duty square wave driving the amplifier input.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz; used to build the half-period table.
- CNT_W, 19, width of the half-period counter; must hold CLK_HZ/524.
- TICK_DIV, 100000, clock cycles per duration tick (1 ms at 100 MHz).
- DUR_W, 8, width of the duration input, in ticks.

Ports:
- clk  in  1  system clock, rising edge.
- hush  in  1  reset, asynchronous, active-low.
- start  in  1  request to play; sampled only in IDLE.
- stop  in  1  abort the current note.
- note  in  3  note code: 0=C4 262 Hz, 1=D4 294, 2=E4 330, 3=F4 349, 4=G4 392, 5=A4 440, 6=B4 494, 7=C5 523.
- octave  in  2  upward octave shift; half-period >> octave.
- dur  in  DUR_W  duration in ticks; 0 = play until stop.
- busy  out  1  high while playing.
- done  out  1  one-cycle pulse when a note ends (expiry or stop).
- ampPWM  out  1  square-wave speaker drive.

Behaviour:
- Reset (hush=0, asynchronous):
  - state=IDLE; busy=0, done=0, ampPWM=0.
  - All counters and latched fields cleared.
- Half-period table:
  - HP[k] = CLK_HZ/(2*F[k]), integer truncation, computed at elaboration.
  - At 100 MHz: 190839, 170068, 151515, 143266, 127551, 113636, 101214, 95602.
  - Effective half-period HPe = HP[note] >> octave, clamped to a minimum of 1.
- State machine: IDLE, PLAY.
- IDLE:
  - ampPWM=0, busy=0.
  - If start=1 and stop=0 at edge n: latch note, octave, dur and HPe; go to PLAY.
  - start together with stop=1 is ignored.
- PLAY:
  - Entered at cycle n+1: busy=1, ampPWM=1.
  - ampPWM toggles every HPe cycles, giving a period of 2*HPe and exactly 50% duty.
  - Tick prescaler starts at 0 on entry and counts TICK_DIV cycles per tick.
  - Duration counter decrements once per tick.
  - Inputs note, octave and dur are ignored while playing; start is ignored (no queueing).
- Expiry (dur>0):
  - busy is high for exactly dur*TICK_DIV cycles (n+1 .. n+dur*TICK_DIV).
  - At cycle n+dur*TICK_DIV+1: busy=0, ampPWM=0, done=1 for one cycle, state=IDLE.
  - A new start in the cycle that done is high is accepted.
- dur=0: plays indefinitely; only stop or hush ends it.
- stop in PLAY at edge m:
  - Cycle m+1: busy=0, ampPWM=0, done=1, state=IDLE.
  - stop coinciding with expiry produces a single done pulse.
- hush asserted mid-note: immediate return to reset values; no done pulse, before or after release.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Bench params for all scenarios: CLK_HZ=8800, TICK_DIV=4, DUR_W=8.
2. start, note=5, octave=0, dur=3 -> busy high 12 cycles; ampPWM high cycles 1-10 then low 11-12 (HPe=10); done pulse cycle 13; ampPWM=0 after.
3. note=0, octave=2, dur=4 -> HPe=16>>2=4; ampPWM 4 high/4 low for 16 cycles, i.e. 2 full periods; single done pulse at cycle 17.
4. note=7, octave=3, dur=1 -> HPe=8>>3=1; ampPWM toggles every cycle for 4 cycles; also pulse start again during busy -> ignored, exactly one done.
5. dur=0, note=4 (HPe=11) -> plays past 100 cycles; stop at cycle 50 -> cycle 51 busy=0, ampPWM=0, done=1; start+stop same cycle in IDLE -> stays IDLE.
6. hush low at cycle 6 of a dur=3 note -> busy, ampPWM, done all 0 immediately; no done after hush release; fresh start afterwards behaves as in scenario 2.
